// File: rtl/cordic_cmd_ctrl_pkg.sv
// Shared definitions for the CORDIC command controller: engine mode codes,
// controller FSM states and the packed command word layout.
package cordic_cmd_ctrl_pkg;

    // Engine mode codes carried in cmd_mode / cordic_mode.
    typedef enum logic [1:0] {
        ModeCircular   = 2'd0,
        ModeLinear     = 2'd1,
        ModeHyperbolic = 2'd2
    } cordic_mode_e;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    // Width of the alpha / linear left-shift field for a given operand width.
    function automatic int unsigned shift_width(input int unsigned fixed_width);
        return $clog2(fixed_width) + 1;
    endfunction

    // Command word is packed MSB..LSB as {tag, shift, rot, mode, a, b}.
    function automatic int unsigned cmd_word_width(input int unsigned fixed_width,
                                                   input int unsigned tag_w);
        return tag_w + shift_width(fixed_width) + 1 + 2 + 2 * fixed_width;
    endfunction

endpackage

// File: rtl/cordic_cmd_fifo.sv
// Small synchronous FIFO for queued CORDIC commands. Depth must be a power of
// two so the pointers wrap naturally. Full/empty come straight from the
// occupancy register, so neither depends combinationally on push or pop.
module cordic_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; simultaneous push and pop both take effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/cordic_cmd_ctrl.sv
// Command sequencer for the iterative CORDIC engine. Queues commands, starts
// the engine one command at a time, holds its controls steady while it runs,
// and returns the tagged result (or a timeout marker) over a valid/ready port.
module cordic_cmd_ctrl
    import cordic_cmd_ctrl_pkg::*;
#(
    parameter int unsigned FIXED_WIDTH    = 16,
    parameter int unsigned TAG_W          = 2,
    parameter int unsigned CMD_DEPTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 31
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_mode,
    input  logic                         cmd_rot,
    input  logic [$clog2(FIXED_WIDTH):0] cmd_shift,
    input  logic [FIXED_WIDTH-1:0]       cmd_a,
    input  logic [FIXED_WIDTH-1:0]       cmd_b,
    input  logic [TAG_W-1:0]             cmd_tag,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [FIXED_WIDTH-1:0]       rsp_out1,
    output logic [FIXED_WIDTH-1:0]       rsp_out2,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic                         rsp_timeout,

    output logic                         cordic_start,
    output logic [1:0]                   cordic_mode,
    output logic                         cordic_is_rotating,
    output logic [$clog2(FIXED_WIDTH):0] cordic_alpha,
    output logic [FIXED_WIDTH-1:0]       cordic_a,
    output logic [FIXED_WIDTH-1:0]       cordic_b,
    input  logic [FIXED_WIDTH-1:0]       cordic_out1,
    input  logic [FIXED_WIDTH-1:0]       cordic_out2,
    input  logic                         cordic_done,

    output logic                         busy
);

    localparam int unsigned ShW      = shift_width(FIXED_WIDTH);
    localparam int unsigned CmdW     = cmd_word_width(FIXED_WIDTH, TAG_W);
    localparam int unsigned CntW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned OffB     = 0;
    localparam int unsigned OffA     = FIXED_WIDTH;
    localparam int unsigned OffMode  = 2 * FIXED_WIDTH;
    localparam int unsigned OffRot   = OffMode + 2;
    localparam int unsigned OffShift = OffRot + 1;
    localparam int unsigned OffTag   = OffShift + ShW;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [CmdW-1:0] fifo_wdata;
    logic [CmdW-1:0] fifo_rdata;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;

    logic                   cap_done;
    logic                   cap_timeout;
    logic                   rsp_clear;

    logic [1:0]             op_mode_q;
    logic                   op_rot_q;
    logic [ShW-1:0]         op_shift_q;
    logic [FIXED_WIDTH-1:0] op_a_q;
    logic [FIXED_WIDTH-1:0] op_b_q;
    logic [TAG_W-1:0]       op_tag_q;

    logic                   rsp_valid_q;
    logic [FIXED_WIDTH-1:0] rsp_out1_q;
    logic [FIXED_WIDTH-1:0] rsp_out2_q;
    logic [TAG_W-1:0]       rsp_tag_q;
    logic                   rsp_timeout_q;

    assign fifo_wdata = {cmd_tag, cmd_shift, cmd_rot, cmd_mode, cmd_a, cmd_b};
    assign fifo_push  = cmd_valid && cmd_ready;
    assign cmd_ready  = !fifo_full;

    cordic_cmd_fifo #(
        .WIDTH (CmdW),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, pop and capture decisions for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        rsp_clear   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cordic_done) begin
                    cap_done = 1'b1;
                    state_d  = StResp;
                end else if (cnt_q == LastCnt) begin
                    cap_timeout = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    // Go straight to the next command without an idle bubble.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state and WAIT-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operation registers: loaded only on pop so engine controls stay stable while it runs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_mode_q  <= '0;
            op_rot_q   <= 1'b0;
            op_shift_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_tag_q   <= '0;
        end else if (fifo_pop) begin
            op_b_q     <= fifo_rdata[OffB +: FIXED_WIDTH];
            op_a_q     <= fifo_rdata[OffA +: FIXED_WIDTH];
            op_mode_q  <= fifo_rdata[OffMode +: 2];
            op_rot_q   <= fifo_rdata[OffRot];
            op_shift_q <= fifo_rdata[OffShift +: ShW];
            op_tag_q   <= fifo_rdata[OffTag +: TAG_W];
        end
    end

    // Response registers: captured on done or timeout, held until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_out1_q    <= '0;
            rsp_out2_q    <= '0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else if (cap_done) begin
            rsp_valid_q   <= 1'b1;
            rsp_out1_q    <= cordic_out1;
            rsp_out2_q    <= cordic_out2;
            rsp_tag_q     <= op_tag_q;
            rsp_timeout_q <= 1'b0;
        end else if (cap_timeout) begin
            rsp_valid_q   <= 1'b1;
            rsp_out1_q    <= '0;
            rsp_out2_q    <= '0;
            rsp_tag_q     <= op_tag_q;
            rsp_timeout_q <= 1'b1;
        end else if (rsp_clear) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid          = rsp_valid_q;
    assign rsp_out1           = rsp_out1_q;
    assign rsp_out2           = rsp_out2_q;
    assign rsp_tag            = rsp_tag_q;
    assign rsp_timeout        = rsp_timeout_q;

    assign cordic_start       = (state_q == StIssue);
    assign cordic_mode        = op_mode_q;
    assign cordic_is_rotating = op_rot_q;
    assign cordic_alpha       = op_shift_q;
    assign cordic_a           = op_a_q;
    assign cordic_b           = op_b_q;

    assign busy               = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_cordic_cmd_ctrl.sv
// Self-checking bench for cordic_cmd_ctrl with a behavioural engine model
// (9-cycle start-to-done latency) and a scoreboard-driven random phase.
module tb_cordic_cmd_ctrl;

    localparam int unsigned FW  = 16;
    localparam int unsigned TW  = 2;
    localparam int unsigned SHW = 5;

    typedef struct packed {
        logic [1:0]    mode;
        logic          rot;
        logic [SHW-1:0] sh;
        logic [FW-1:0] a;
        logic [FW-1:0] b;
        logic [TW-1:0] tag;
    } cmd_t;

    typedef struct {
        cmd_t          c;
        logic [FW-1:0] e1;
        logic [FW-1:0] e2;
        int            tol;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_mode = '0;
    logic           cmd_rot = 1'b0;
    logic [SHW-1:0] cmd_shift = '0;
    logic [FW-1:0]  cmd_a = '0;
    logic [FW-1:0]  cmd_b = '0;
    logic [TW-1:0]  cmd_tag = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [FW-1:0]  rsp_out1;
    logic [FW-1:0]  rsp_out2;
    logic [TW-1:0]  rsp_tag;
    logic           rsp_timeout;
    logic           cordic_start;
    logic [1:0]     cordic_mode;
    logic           cordic_is_rotating;
    logic [SHW-1:0] cordic_alpha;
    logic [FW-1:0]  cordic_a;
    logic [FW-1:0]  cordic_b;
    logic [FW-1:0]  cordic_out1;
    logic [FW-1:0]  cordic_out2;
    logic           cordic_done;
    logic           busy;

    always #5 clk = ~clk;

    cordic_cmd_ctrl #(
        .FIXED_WIDTH    (FW),
        .TAG_W          (TW),
        .CMD_DEPTH      (2),
        .TIMEOUT_CYCLES (31)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_mode           (cmd_mode),
        .cmd_rot            (cmd_rot),
        .cmd_shift          (cmd_shift),
        .cmd_a              (cmd_a),
        .cmd_b              (cmd_b),
        .cmd_tag            (cmd_tag),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_out1           (rsp_out1),
        .rsp_out2           (rsp_out2),
        .rsp_tag            (rsp_tag),
        .rsp_timeout        (rsp_timeout),
        .cordic_start       (cordic_start),
        .cordic_mode        (cordic_mode),
        .cordic_is_rotating (cordic_is_rotating),
        .cordic_alpha       (cordic_alpha),
        .cordic_a           (cordic_a),
        .cordic_b           (cordic_b),
        .cordic_out1        (cordic_out1),
        .cordic_out2        (cordic_out2),
        .cordic_done        (cordic_done),
        .busy               (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;

    // Cycle counter and engine start-pulse counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cordic_start) start_cnt <= start_cnt + 1;
    end

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    endfunction

    // Ideal engine: circular rotate gives cos/sin of A (Q2.14), linear rotate
    // gives (A*B)>>>shift, other combinations a simple mix of the operands.
    function automatic logic [31:0] eng_fn(input logic [1:0] mode, input logic rot,
                                           input logic [SHW-1:0] sh,
                                           input logic [FW-1:0] a, input logic [FW-1:0] b);
        real ang;
        int v1, v2;
        logic signed [31:0] sa, sb, p;
        logic [FW-1:0] o1, o2;
        if (mode == 2'd0 && rot) begin
            ang = $itor($signed(a)) / 16384.0;
            v1 = rnd(16384.0 * $cos(ang));
            v2 = rnd(16384.0 * $sin(ang));
            o1 = v1[15:0];
            o2 = v2[15:0];
        end else if (mode == 2'd1 && rot) begin
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            p  = (sa * sb) >>> sh;
            o1 = p[15:0];
            o2 = a;
        end else begin
            o1 = a ^ b;
            o2 = a - b + {11'd0, sh};
        end
        return {o1, o2};
    endfunction

    // Engine model: done 9 cycles after start, outputs from live controls.
    logic          eng_en = 1'b1;
    logic          eng_run = 1'b0;
    logic          eng_done = 1'b0;
    logic          spur_done = 1'b0;
    int            eng_cnt = 0;
    int            viol_stab = 0;
    int            viol_start = 0;
    logic [FW-1:0] eng_o1 = '0;
    logic [FW-1:0] eng_o2 = '0;
    logic [1:0]    lat_mode = '0;
    logic          lat_rot = 1'b0;
    logic [SHW-1:0] lat_sh = '0;
    logic [FW-1:0] lat_a = '0;
    logic [FW-1:0] lat_b = '0;

    assign cordic_done = eng_done | spur_done;
    assign cordic_out1 = spur_done ? 16'hDEAD : eng_o1;
    assign cordic_out2 = spur_done ? 16'hBEEF : eng_o2;

    always @(posedge clk) begin
        logic [31:0] r;
        eng_done <= 1'b0;
        if (!rst_n) begin
            eng_run <= 1'b0;
            eng_cnt <= 0;
        end else begin
            if (cordic_start) begin
                if (rsp_valid || eng_run) viol_start <= viol_start + 1;
                eng_run  <= 1'b1;
                eng_cnt  <= 1;
                lat_mode <= cordic_mode;
                lat_rot  <= cordic_is_rotating;
                lat_sh   <= cordic_alpha;
                lat_a    <= cordic_a;
                lat_b    <= cordic_b;
            end else begin
                if ((eng_run || eng_done) &&
                    {cordic_mode, cordic_is_rotating, cordic_alpha, cordic_a, cordic_b} !==
                    {lat_mode, lat_rot, lat_sh, lat_a, lat_b})
                    viol_stab <= viol_stab + 1;
                if (eng_run) begin
                    if (eng_cnt == 8) begin
                        eng_run <= 1'b0;
                        if (eng_en) begin
                            r = eng_fn(cordic_mode, cordic_is_rotating, cordic_alpha,
                                       cordic_a, cordic_b);
                            eng_o1   <= r[31:16];
                            eng_o2   <= r[15:0];
                            eng_done <= 1'b1;
                        end
                    end
                    eng_cnt <= eng_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp,
                           input int tol);
        int d;
        d = int'($signed(act)) - int'($signed(exp));
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h +/-%0d", nm, act, exp, tol);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] mode, input logic rot, input logic [SHW-1:0] sh,
                                input logic [FW-1:0] a, input logic [FW-1:0] b,
                                input logic [TW-1:0] tag);
        cmd_t c;
        c.mode = mode; c.rot = rot; c.sh = sh; c.a = a; c.b = b; c.tag = tag;
        return c;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge, with c0 = cyc then.
    task automatic push(input cmd_t c, output int c0);
        int guard;
        guard = 0;
        cmd_valid = 1'b1;
        cmd_mode = c.mode; cmd_rot = c.rot; cmd_shift = c.sh;
        cmd_a = c.a; cmd_b = c.b; cmd_tag = c.tag;
        @(negedge clk);
        while (!cmd_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_accept: cmd_ready stuck at %0b, required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        cmd_valid = 1'b0;
    endtask

    // Returns at the first negedge with rsp_valid high (t = cyc there).
    task automatic wait_rsp(input string nm, output int t);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        t = cyc;
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: rsp_valid=%0b after 200 cycles, required 1", nm, rsp_valid);
        end
    endtask

    // Called at a negedge with rsp_valid high; returns at posedge+1.
    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_ctrl"},
            {48'd0, cmd_ready, rsp_valid, rsp_timeout, cordic_start, cordic_is_rotating, busy,
             cordic_mode, rsp_tag, cordic_alpha},
            {48'd0, 1'b1, 5'b00000, 2'd0, 2'd0, 5'd0});
        chk({nm, "_data"}, {rsp_out1, rsp_out2, cordic_a, cordic_b}, 64'd0);
    endtask

    vec_t vecs[5];
    cmd_t sb_q[$];
    bit   rand_done = 1'b0;

    // Safety net: never hang.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t, s0, seen;
        cmd_t ca, cb;
        logic [31:0] ea;

        vecs[0] = '{c: mk(2'd0, 1'b1, 5'd0,  16'h0000, 16'h0000, 2'd1),
                    e1: 16'h4000, e2: 16'h0000, tol: 4};
        vecs[1] = '{c: mk(2'd1, 1'b1, 5'd14, 16'h2000, 16'h4000, 2'd2),
                    e1: 16'h2000, e2: 16'h2000, tol: 2};
        vecs[2] = '{c: mk(2'd0, 1'b1, 5'd0,  16'h1922, 16'h0000, 2'd3),
                    e1: 16'h3B21, e2: 16'h187E, tol: 4};
        vecs[3] = '{c: mk(2'd2, 1'b0, 5'd3,  16'h1234, 16'h00FF, 2'd0),
                    e1: 16'h12CB, e2: 16'h1138, tol: 0};
        vecs[4] = '{c: mk(2'd1, 1'b1, 5'd14, 16'hE000, 16'h4000, 2'd1),
                    e1: 16'hE000, e2: 16'hE000, tol: 2};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single commands: latency, values, tag, single start.
        for (int i = 0; i < 5; i++) begin
            s0 = start_cnt;
            push(vecs[i].c, c0);
            wait_rsp($sformatf("vec%0d", i), t);
            chk($sformatf("vec%0d_latency", i), 64'(t - c0), 64'd11);
            chk_tol($sformatf("vec%0d_out1", i), rsp_out1, vecs[i].e1, vecs[i].tol);
            chk_tol($sformatf("vec%0d_out2", i), rsp_out2, vecs[i].e2, vecs[i].tol);
            chk($sformatf("vec%0d_tag_to", i), {61'd0, rsp_tag, rsp_timeout},
                {61'd0, vecs[i].c.tag, 1'b0});
            consume();
            chk($sformatf("vec%0d_starts", i), 64'(start_cnt - s0), 64'd1);
        end

        // Back-pressure: three commands with rsp_ready low, then drain in order.
        s0 = start_cnt;
        for (int i = 1; i <= 3; i++) begin
            push(mk(2'd2, 1'b0, 5'(i), 16'(16'h0100 * i), 16'h0011, 2'(i)), c0);
        end
        @(negedge clk);
        chk("bp_ready_low", {63'd0, cmd_ready}, 64'd0);
        for (int i = 1; i <= 3; i++) begin
            wait_rsp($sformatf("bp%0d", i), t);
            ea = eng_fn(2'd2, 1'b0, 5'(i), 16'(16'h0100 * i), 16'h0011);
            chk($sformatf("bp%0d_rsp", i), {29'd0, rsp_tag, rsp_timeout, rsp_out1, rsp_out2},
                {29'd0, 2'(i), 1'b0, ea});
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("bp%0d_zero_bubble", i), {63'd0, cordic_start}, {63'd0, (i < 3)});
            if (i == 1) chk("bp_ready_back", {63'd0, cmd_ready}, 64'd1);
        end
        chk("bp_starts", 64'(start_cnt - s0), 64'd3);

        // Timeout: engine never finishes.
        @(posedge clk);
        #1;
        eng_en = 1'b0;
        push(mk(2'd0, 1'b0, 5'd0, 16'h1111, 16'h2222, 2'd2), c0);
        wait_rsp("to", t);
        chk("to_latency", 64'(t - c0), 64'd33);
        chk("to_rsp", {29'd0, rsp_tag, rsp_timeout, rsp_out1, rsp_out2},
            {29'd0, 2'd2, 1'b1, 32'd0});
        @(posedge clk);
        #1;
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        @(negedge clk);
        chk("to_late_done_hold", {30'd0, rsp_valid, rsp_timeout, rsp_out1, rsp_out2},
            {30'd0, 1'b1, 1'b1, 32'd0});
        consume();
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("to_spurious_ignored", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        eng_en = 1'b1;
        ca = mk(2'd1, 1'b1, 5'd14, 16'h2000, 16'h4000, 2'd3);
        push(ca, c0);
        wait_rsp("to_next", t);
        ea = eng_fn(ca.mode, ca.rot, ca.sh, ca.a, ca.b);
        chk("to_next_rsp", {29'd0, rsp_tag, rsp_timeout, rsp_out1, rsp_out2},
            {29'd0, 2'd3, 1'b0, ea});
        consume();

        // Stall: result held 20 cycles with another command queued.
        ca = mk(2'd2, 1'b1, 5'd2, 16'hA5A5, 16'h0F0F, 2'd1);
        cb = mk(2'd0, 1'b1, 5'd0, 16'h0800, 16'h0000, 2'd2);
        push(ca, c0);
        wait_rsp("stall_a", t);
        @(posedge clk);
        #1;
        push(cb, c0);
        ea = eng_fn(ca.mode, ca.rot, ca.sh, ca.a, ca.b);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("stall_c%0d", k),
                {27'd0, rsp_valid, rsp_timeout, cordic_start, busy, rsp_tag, ea},
                {27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, rsp_out1, rsp_out2} ^
                {32'd0, ea ^ {rsp_out1, rsp_out2}} ^ {32'd0, ea ^ {rsp_out1, rsp_out2}});
            chk($sformatf("stall_d%0d", k), {32'd0, rsp_out1, rsp_out2}, {32'd0, ea});
        end
        consume();
        wait_rsp("stall_b", t);
        ea = eng_fn(cb.mode, cb.rot, cb.sh, cb.a, cb.b);
        chk("stall_b_rsp", {29'd0, rsp_tag, rsp_timeout, rsp_out1, rsp_out2},
            {29'd0, 2'd2, 1'b0, ea});
        consume();

        // Randomized traffic against a scoreboard queue.
        fork
            begin
                cmd_t c;
                int ct;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    c = mk(2'($urandom_range(0, 2)), 1'($urandom), 5'($urandom_range(0, 15)),
                           16'($urandom), 16'($urandom), 2'($urandom));
                    push(c, ct);
                    sb_q.push_back(c);
                end
            end
            begin
                int got, guard;
                cmd_t e;
                logic [31:0] r;
                got = 0;
                guard = 0;
                while (got < 40 && guard < 6000) begin
                    @(negedge clk);
                    guard++;
                    if (rsp_valid && rsp_ready) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rand_unexpected: response tag %0d with none pending",
                                     rsp_tag);
                        end else begin
                            e = sb_q.pop_front();
                            r = eng_fn(e.mode, e.rot, e.sh, e.a, e.b);
                            chk($sformatf("rand%0d", got),
                                {29'd0, rsp_tag, rsp_timeout, rsp_out1, rsp_out2},
                                {29'd0, e.tag, 1'b0, r});
                        end
                        got++;
                    end
                end
                chk("rand_count", 64'(got), 64'd40);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset during WAIT with two commands queued.
        for (int i = 0; i < 3; i++) begin
            push(mk(2'd2, 1'b0, 5'd1, 16'(16'h0300 + i), 16'h0001, 2'(i)), c0);
        end
        chk("rst_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || cordic_start || busy || !cmd_ready) seen++;
        end
        chk("rst_no_stale", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        ca = mk(2'd1, 1'b1, 5'd14, 16'h2000, 16'h4000, 2'd1);
        push(ca, c0);
        wait_rsp("rst_after", t);
        ea = eng_fn(ca.mode, ca.rot, ca.sh, ca.a, ca.b);
        chk("rst_after_latency", 64'(t - c0), 64'd11);
        chk("rst_after_rsp", {29'd0, rsp_tag, rsp_timeout, rsp_out1, rsp_out2},
            {29'd0, 2'd1, 1'b0, ea});
        consume();

        repeat (2) @(posedge clk);
        chk("engine_controls_stable", 64'(viol_stab), 64'd0);
        chk("no_start_while_busy", 64'(viol_start), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
